eq_gain_scheduler: RTL

- Gain-configuration controller for the 8-band equalizer datapath; it drives that block's per-band signed 8-bit gain vector g.
- Software/host writes individual band gains into shadow registers over a valid/ready port.
- A commit handshake snapshots all shadows as a new target set. The target takes effect only on a sample boundary.
- Active gains then ramp toward the target by a bounded step per sample, avoiding zipper noise on the 16-bit audio stream.

---
 rtl/eq_cfg_pkg.sv | 30 +++
 rtl/eq_gain_scheduler_if.sv | 31 +++
 rtl/eq_gain_ramp_lane.sv | 57 +++++
 rtl/eq_gain_scheduler.sv | 133 +++++++++++++
 4 files changed

// File: rtl/eq_cfg_pkg.sv
// -----------------------------------------------------------------------------
// eq_cfg_pkg
// Shared types and constants for the equalizer gain scheduler.
//   NBANDS       : number of equalizer bands
//   GW           : gain width (signed two's complement)
//   BAND_W       : width of the band index on the write port
//   DEFAULT_GAIN : reset value for shadow, target and active gains (unity)
//   gain_t       : one signed band gain
//   gain_vec_t   : packed vector of all band gains, element k is band k
//   state_t      : scheduler FSM states
// -----------------------------------------------------------------------------
package eq_cfg_pkg;

    localparam int NBANDS       = 8;
    localparam int GW           = 8;
    localparam int BAND_W       = 3;
    localparam int DEFAULT_GAIN = 1;

    typedef logic signed [GW-1:0]   gain_t;
    typedef gain_t [NBANDS-1:0]     gain_vec_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        RAMP    = 2'd2
    } state_t;

    localparam gain_t DEFAULT_G = gain_t'(DEFAULT_GAIN);

endpackage

// File: rtl/eq_gain_scheduler_if.sv
// -----------------------------------------------------------------------------
// eq_gain_scheduler_if
// Host-side configuration port of the gain scheduler.
//   wr_valid/wr_ready         : band-gain write handshake
//   wr_band/wr_gain           : band index and signed gain for the write
//   commit_valid/commit_ready : commit handshake (snapshot shadows as target)
// Modports:
//   master : host driving writes and commits
//   slave  : the scheduler
// -----------------------------------------------------------------------------
interface eq_gain_scheduler_if;
    import eq_cfg_pkg::*;

    logic              wr_valid;
    logic              wr_ready;
    logic [BAND_W-1:0] wr_band;
    gain_t             wr_gain;
    logic              commit_valid;
    logic              commit_ready;

    modport master (
        output wr_valid, wr_band, wr_gain, commit_valid,
        input  wr_ready, commit_ready
    );

    modport slave (
        input  wr_valid, wr_band, wr_gain, commit_valid,
        output wr_ready, commit_ready
    );

endinterface

// File: rtl/eq_gain_ramp_lane.sv
// -----------------------------------------------------------------------------
// eq_gain_ramp_lane
// One band of the gain ramp: holds the active gain and moves it toward the
// target by at most STEP each time step_en is asserted.
//   clk       : system clock
//   rst       : synchronous active-high reset, active returns to DEFAULT_G
//   step_en   : perform one ramp step this cycle
//   target    : gain this band is ramping toward
//   active    : registered active gain
//   at_target : the stepped value equals target (i.e. this band is done once
//               the current step is applied); only meaningful with step_en
// -----------------------------------------------------------------------------
module eq_gain_ramp_lane
    import eq_cfg_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  step_en,
    input  gain_t target,
    output gain_t active,
    output logic  at_target
);

    localparam logic signed [GW:0] STEP_W = (GW+1)'(STEP);
    localparam gain_t               STEP_G = gain_t'(STEP);

    gain_t             r_active;
    logic signed [GW:0] w_diff;
    gain_t             w_next;

    // Difference is taken one bit wider so -128..127 extremes cannot wrap.
    // Moving by STEP only when |diff| > STEP keeps active+/-STEP in range.
    always_comb begin
        w_diff = $signed({target[GW-1], target}) - $signed({r_active[GW-1], r_active});
        if (w_diff > STEP_W) begin
            w_next = r_active + STEP_G;
        end else if (w_diff < -STEP_W) begin
            w_next = r_active - STEP_G;
        end else begin
            w_next = target;
        end
    end

    assign at_target = (w_next == target);
    assign active    = r_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= DEFAULT_G;
        end else if (step_en) begin
            r_active <= w_next;
        end
    end

endmodule

// File: rtl/eq_gain_scheduler.sv
// -----------------------------------------------------------------------------
// eq_gain_scheduler
// Gain-configuration controller for the 8-band equalizer. The host writes
// per-band gains into shadow registers, commits them as a new target set, and
// the active gains ramp toward that target by at most STEP per audio sample.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   sample_en : one-cycle strobe marking a new audio sample
//   bus       : host write/commit port (eq_gain_scheduler_if.slave)
//   g         : registered active gains, g[k] for band k
//   busy      : registered, high while a commit is pending or a ramp runs
// -----------------------------------------------------------------------------
module eq_gain_scheduler
    import eq_cfg_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_en,
    eq_gain_scheduler_if.slave   bus,
    output gain_vec_t            g,
    output logic                 busy
);

    gain_t             r_shadow [NBANDS];
    gain_t             r_target [NBANDS];
    gain_t             w_shadow_nxt [NBANDS];
    state_t            r_state;
    logic              r_busy;
    logic              r_commit_ready;
    logic              w_commit_acc;
    logic              w_step_en;
    logic [NBANDS-1:0] w_at_target;
    logic              w_all_done;

    assign bus.wr_ready     = 1'b1;
    assign bus.commit_ready = r_commit_ready;
    assign busy             = r_busy;

    assign w_commit_acc = bus.commit_valid && r_commit_ready;
    // Lanes only move outside IDLE; a commit seen in IDLE together with
    // sample_en therefore latches the target without stepping.
    assign w_step_en    = sample_en && (r_state != IDLE);
    assign w_all_done   = &w_at_target;

    // Shadow with this cycle's write applied; the commit snapshot reads this
    // so a write accepted alongside the commit is included. Out-of-range band
    // indices match no entry and are dropped.
    always_comb begin
        for (int k = 0; k < NBANDS; k++) begin
            w_shadow_nxt[k] = r_shadow[k];
            if (bus.wr_valid && bus.wr_ready && (bus.wr_band == BAND_W'(k))) begin
                w_shadow_nxt[k] = bus.wr_gain;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NBANDS; k++) begin
                r_shadow[k] <= DEFAULT_G;
                r_target[k] <= DEFAULT_G;
            end
        end else begin
            for (int k = 0; k < NBANDS; k++) begin
                r_shadow[k] <= w_shadow_nxt[k];
                if (w_commit_acc) begin
                    r_target[k] <= w_shadow_nxt[k];
                end
            end
        end
    end

    for (genvar k = 0; k < NBANDS; k++) begin : g_lane
        eq_gain_ramp_lane #(
            .STEP      (STEP)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .step_en   (w_step_en),
            .target    (r_target[k]),
            .active    (g[k]),
            .at_target (w_at_target[k])
        );
    end

    // Control FSM. busy and commit_ready are registered alongside the state.
    // The done test uses the post-step values, so the step that lands the
    // last band on target also returns to IDLE. A commit accepted in RAMP
    // keeps the FSM in RAMP even if the old target was just reached, since
    // the new target may differ from the active gains.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_busy         <= 1'b0;
            r_commit_ready <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_commit_acc) begin
                        r_state        <= PENDING;
                        r_busy         <= 1'b1;
                        r_commit_ready <= 1'b0;
                    end
                end
                PENDING: begin
                    if (sample_en) begin
                        r_commit_ready <= 1'b1;
                        if (w_all_done) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= RAMP;
                        end
                    end
                end
                RAMP: begin
                    if (!w_commit_acc && sample_en && w_all_done) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state        <= IDLE;
                    r_busy         <= 1'b0;
                    r_commit_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
